// File: rtl/dac_writer_pkg.sv
// Shared definitions for the DAC7311-class serial writer: FSM states, default register
// addresses and the 16-bit frame word layout.
package dac_writer_pkg;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_P0, S_P1, S_P2, S_P3, S_END, S_GAPW
   } state_t;

   localparam logic [7:0]  DEF_BASE    = 8'h10;
   localparam logic [7:0]  DEF_CTRL    = 8'h18;
   localparam logic [15:0] RD_UNMAPPED = 16'hF001;

   localparam int FW_PD_MSB   = 15;
   localparam int FW_PD_LSB   = 14;
   localparam int FW_DATA_MSB = 13;
   localparam int FW_DATA_LSB = 2;

   // {pd, setpoint, 2'b00}; the two trailing bits are don't-care for the DAC
   function automatic logic [15:0] frame_word(input logic [1:0] pd, input logic [11:0] sp);
      logic [15:0] w;
      w = '0;
      w[FW_PD_MSB:FW_PD_LSB]     = pd;
      w[FW_DATA_MSB:FW_DATA_LSB] = sp;
      return w;
   endfunction

endpackage

// File: rtl/dac_writer_shift_chan.sv
// Per-DAC 16-bit load/shift register; the MSB drives that DAC's DIN line.
module dac_shift_chan (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_load,
   input  logic        i_shift,
   input  logic [15:0] i_word,
   output logic        o_msb
);

   logic [15:0] r_sr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        r_sr <= '0;
      else if (i_load)  r_sr <= i_word;
      else if (i_shift) r_sr <= {r_sr[14:0], 1'b0};
   end

   assign o_msb = r_sr[15];

endmodule

// File: rtl/dac_writer.sv
// Register-bus controlled serial writer: sends one 16-bit frame to NCH DACs in parallel
// over shared SYNC_n/SCLK with one DIN per DAC; SCLK = clk/4, all pins registered.
module dac_writer
   import dac_writer_pkg::*;
#(
   parameter int         NCH  = 6,
   parameter logic [7:0] BASE = DEF_BASE,
   parameter logic [7:0] CTRL = DEF_CTRL,
   parameter int         GAP  = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            reg_we_i,
   input  logic [7:0]      reg_addr_i,
   input  logic [15:0]     reg_data_i,
   output logic [15:0]     reg_data_o,
   output logic            dac_sync_n_o,
   output logic            dac_sclk_o,
   output logic [NCH-1:0]  dac_din_o,
   output logic            busy_o
);

   localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;

   state_t         r_state, w_state_nx;
   logic [11:0]    r_sp [NCH];
   logic [1:0]     r_pd;
   logic           r_pending;
   logic [3:0]     r_bit;
   logic [GW-1:0]  r_gap;
   logic           r_sync_n, r_sclk, r_busy;
   logic [NCH-1:0] r_din;
   logic [NCH-1:0] w_msb;
   logic [8:0]     w_off;
   logic           w_is_ch, w_is_ctrl, w_set_pend, w_load, w_shift;

   assign w_off      = {1'b0, reg_addr_i} - {1'b0, BASE};
   assign w_is_ctrl  = (reg_addr_i == CTRL);
   assign w_is_ch    = !w_off[8] && (w_off[7:0] < 8'(NCH)) && !w_is_ctrl;
   assign w_set_pend = reg_we_i && (w_is_ch || (w_is_ctrl && reg_data_i[0]));

   // A write in the LOAD cycle must win over the clear so it is not lost
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NCH; k++) r_sp[k] <= '0;
         r_pd      <= '0;
         r_pending <= 1'b0;
      end else begin
         if (reg_we_i && w_is_ch)
            for (int k = 0; k < NCH; k++)
               if (w_off[7:0] == 8'(k)) r_sp[k] <= reg_data_i[11:0];
         if (reg_we_i && w_is_ctrl) r_pd <= reg_data_i[2:1];
         if (w_set_pend)            r_pending <= 1'b1;
         else if (w_load)           r_pending <= 1'b0;
      end
   end

   always_comb begin
      reg_data_o = RD_UNMAPPED;
      if (w_is_ctrl)
         reg_data_o = {12'b0, r_pending, r_pd, r_busy};
      else if (w_is_ch)
         for (int k = 0; k < NCH; k++)
            if (w_off[7:0] == 8'(k)) reg_data_o = {4'b0, r_sp[k]};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_load     = 1'b0;
      w_shift    = 1'b0;
      case (r_state)
         S_IDLE: if (r_pending) w_state_nx = S_LOAD;
         S_LOAD: begin
            w_load     = 1'b1;
            w_state_nx = S_P0;
         end
         S_P0:   w_state_nx = S_P1;
         S_P1:   w_state_nx = S_P2;
         S_P2:   w_state_nx = S_P3;
         S_P3: begin
            w_shift    = 1'b1;
            w_state_nx = (r_bit == 4'd0) ? S_END : S_P0;
         end
         S_END:  w_state_nx = S_GAPW;
         S_GAPW: if (r_gap == '0) w_state_nx = r_pending ? S_LOAD : S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // END is the first high cycle of the gap, so GAPW lasts GAP-1 cycles
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bit <= '0;
         r_gap <= '0;
      end else begin
         if (w_load)                       r_bit <= 4'd15;
         else if (w_shift && r_bit != 4'd0) r_bit <= r_bit - 4'd1;
         if (r_state == S_END)                     r_gap <= GW'(GAP - 2);
         else if (r_state == S_GAPW && r_gap != '0) r_gap <= r_gap - 1'b1;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [15:0] w_word;
      assign w_word = frame_word(r_pd, r_sp[k]);
      dac_shift_chan u_chan (
         .i_clk   (clk_i),
         .i_rst   (rst_i),
         .i_load  (w_load),
         .i_shift (w_shift),
         .i_word  (w_word),
         .o_msb   (w_msb[k])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync_n <= 1'b1;
         r_sclk   <= 1'b1;
         r_din    <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_sync_n <= (r_state inside {S_IDLE, S_END, S_GAPW});
         r_sclk   <= !(r_state inside {S_P2, S_P3});
         r_busy   <= (r_state != S_IDLE);
         case (r_state)
            S_P0:             r_din <= w_msb;
            S_P1, S_P2, S_P3: r_din <= r_din;
            default:          r_din <= '0;
         endcase
      end
   end

   assign dac_sync_n_o = r_sync_n;
   assign dac_sclk_o   = r_sclk;
   assign dac_din_o    = r_din;
   assign busy_o       = r_busy;

endmodule

// File: tb/tb_dac_writer.sv
// Randomized and directed bench for dac_writer against a frame-position reference model.
module tb_dac_writer;

   localparam int NCH  = 6;
   localparam int GAP  = 4;
   localparam int FLEN = 65 + GAP;

   typedef logic [NCH-1:0][15:0] frame_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            we = 1'b0;
   logic [7:0]      addr = 8'h00;
   logic [15:0]     wdata = 16'h0000;
   logic [15:0]     rdata;
   logic            sync_n, sclk, busy;
   logic [NCH-1:0]  din;

   int npass = 0;
   int ntotal = 0;

   dac_writer #(.NCH(NCH), .BASE(8'h10), .CTRL(8'h18), .GAP(GAP)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .reg_we_i     (we),
      .reg_addr_i   (addr),
      .reg_data_i   (wdata),
      .reg_data_o   (rdata),
      .dac_sync_n_o (sync_n),
      .dac_sclk_o   (sclk),
      .dac_din_o    (din),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: position within a frame (0 = load cycle, -1 = idle); pins lag by one.
   int          mpos = -1, mpin = -1, mnext, ma;
   bit          mpend = 1'b0, mnpend;
   logic [1:0]  mpd = 2'b00;
   logic [11:0] msp [NCH];
   logic [15:0] mshadow [NCH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mpos = -1; mpin = -1; mpend = 1'b0; mpd = 2'b00;
         for (int k = 0; k < NCH; k++) begin msp[k] = '0; mshadow[k] = '0; end
      end else begin
         mpin   = mpos;
         mnpend = mpend;
         if (mpos == 0) begin
            for (int k = 0; k < NCH; k++) mshadow[k] = {mpd, msp[k], 2'b00};
            mnpend = 1'b0;
         end
         if (mpos == -1)           mnext = mpend ? 0 : -1;
         else if (mpos < FLEN - 1) mnext = mpos + 1;
         else                      mnext = mpend ? 0 : -1;
         if (we) begin
            ma = int'(addr);
            if (ma >= 'h10 && ma < 'h10 + NCH) begin
               msp[ma - 'h10] = wdata[11:0];
               mnpend = 1'b1;
            end else if (ma == 'h18) begin
               mpd = wdata[2:1];
               if (wdata[0]) mnpend = 1'b1;
            end
         end
         mpend = mnpend;
         mpos  = mnext;
      end
   end

   function automatic logic [15:0] exp_rd(input logic [7:0] a);
      int ai = int'(a);
      if (ai == 'h18) return {12'b0, mpend, mpd, (mpin != -1)};
      if (ai >= 'h10 && ai < 'h10 + NCH) return {4'b0, msp[ai - 'h10]};
      return 16'hF001;
   endfunction

   always @(negedge clk) begin
      logic [NCH-1:0] edin;
      bit inframe;
      inframe = (mpin >= 1 && mpin <= 64);
      for (int k = 0; k < NCH; k++)
         edin[k] = inframe ? mshadow[k][15 - (mpin - 1) / 4] : 1'b0;
      chk("sync_n", sync_n, !(mpin >= 0 && mpin <= 64));
      chk("sclk",   sclk,   !(inframe && ((mpin - 1) % 4) >= 2));
      chk("din",    din,    edin);
      chk("busy",   busy,   (mpin != -1));
      chk("rdata",  rdata,  exp_rd(addr));
   end

   // Frame capture as a DAC would see it: sample on falling SCLK while SYNC_n is low
   frame_t capf;
   frame_t frames[$];
   int     ncap = 0;

   always @(negedge sclk) begin
      if (!sync_n && !rst) begin
         for (int k = 0; k < NCH; k++) capf[k] = {capf[k][14:0], din[k]};
         ncap++;
      end
   end

   always @(posedge sync_n) begin
      if (!rst) begin
         chk("frame_bits", ncap, 16);
         frames.push_back(capf);
      end
      ncap = 0;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      tick();
      we = 1'b1; addr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         tick();
         if (!busy && mpos == -1 && !mpend) ok = 1'b1;
      end
      ntotal++;
      if (ok) npass++;
      else $display("FAIL %s: busy %0b still set, expected idle within 1000 cycles", nm, busy);
      repeat (2) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      frame_t f;
      logic [15:0] tbl [6];

      // reset values before any clock edge
      #1 rst = 1'b1;
      #2;
      chk("rst_sync", sync_n, 1); chk("rst_sclk", sclk, 1);
      chk("rst_din", din, 0);     chk("rst_busy", busy, 0);
      repeat (3) tick();
      rst = 1'b0;

      // single write, ch0 = 0xABC
      wr(8'h10, 16'h0ABC);
      tick(); chk("sync_before", sync_n, 1);
      tick(); chk("sync_fall_2", sync_n, 0);
      wait_idle("single");
      chk("single_nframes", frames.size(), 1);
      f = frames[frames.size() - 1];
      chk("single_ch0", f[0], 16'h2AF0);
      chk("single_ch1", f[1], 16'h0000);

      // power-down bits with forced resend
      wr(8'h18, 16'h0005);
      repeat (10) tick();
      addr = 8'h18; #1;
      chk("ctrl_read", rdata, 16'h0005);
      wait_idle("pd");
      f = frames[frames.size() - 1];
      chk("pd_ch0", f[0], 16'hAAF0);
      chk("pd_ch3", f[3], 16'h8000);
      wr(8'h18, 16'h0000);

      // writes during a frame: in-flight shadow kept, exactly one follow-up frame
      n0 = frames.size();
      wr(8'h18, 16'h0001);
      repeat (13) tick();
      wr(8'h11, 16'h0123);
      repeat (21) tick();
      wr(8'h11, 16'h0456);
      wait_idle("midframe");
      chk("mid_nframes", frames.size(), n0 + 2);
      if (frames.size() >= n0 + 2) begin
         chk("mid_first_ch1", frames[n0][1], 16'h0000);
         chk("mid_second_ch1", frames[n0 + 1][1], 16'h1158);
      end

      // register readback and unmapped address
      tbl = '{16'h0ABC, 16'h0456, 16'hF321, 16'h0FFF, 16'h8000, 16'h1234};
      for (int i = 2; i < 6; i++) wr(8'h10 + 8'(i), tbl[i]);
      wait_idle("reads");
      for (int i = 0; i < 6; i++) begin
         addr = 8'h10 + 8'(i); #1;
         chk($sformatf("read_ch%0d", i), rdata, tbl[i] & 16'h0FFF);
      end
      addr = 8'h20; #1;
      chk("read_unmapped", rdata, 16'hF001);
      n0 = frames.size();
      wr(8'h20, 16'hFFFF);
      repeat (100) tick();
      chk("unmapped_nframes", frames.size(), n0);
      chk("unmapped_busy", busy, 0);

      // write in the LOAD cycle
      n0 = frames.size();
      tick(); we = 1'b1; addr = 8'h12; wdata = 16'h0100;
      tick(); we = 1'b0;
      tick(); we = 1'b1; wdata = 16'h0FFF;
      tick(); we = 1'b0;
      addr = 8'h18; #1;
      chk("load_collide_ctrl", rdata, 16'h0009);
      wait_idle("collide");
      chk("collide_nframes", frames.size(), n0 + 2);
      if (frames.size() >= n0 + 2) begin
         chk("collide_first", frames[n0][2], 16'h0400);
         chk("collide_second", frames[n0 + 1][2], 16'h3FFC);
      end

      // randomized traffic, checked cycle by cycle by the model
      for (int c = 0; c < 2500; c++) begin
         int pick;
         tick();
         we = 1'b0;
         pick = $urandom_range(0, 11);
         addr = (pick < 8) ? 8'h10 + 8'(pick) : (pick < 10) ? 8'h18 :
                (pick == 10) ? 8'h20 : 8'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            we = 1'b1;
            wdata = 16'($urandom);
         end
      end
      tick(); we = 1'b0;
      wait_idle("random");

      // async reset mid-frame (bit 7) aborts the frame and leaves nothing pending
      wr(8'h10, 16'h0555);
      repeat (30) tick();
      chk("pre_rst_sync", sync_n, 0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_sync", sync_n, 1); chk("midrst_sclk", sclk, 1);
      chk("midrst_din", din, 0);     chk("midrst_busy", busy, 0);
      repeat (3) tick();
      rst = 1'b0;
      n0 = frames.size();
      repeat (200) tick();
      chk("post_rst_nframes", frames.size(), n0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_sync", sync_n, 1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
